mult_seq: RTL

- Iterative shift-add multiplier that answers the execute-stage ALU's multiply request. The ALU initiates the request; this block is the responder on the same opn_valid / res_valid / res_ready protocol.
- Produces a full 2*WIDTH-bit product {hi, lo}, signed or unsigned, in a fixed number of cycles.
- The ALU holds opn_valid and stalls the pipeline until res_valid is high. It drives res_ready = ~stallE.

---
 rtl/mult_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier answering the ALU multiply request.
// Produces a full 2*WIDTH-bit signed or unsigned product in WIDTH+1 edges.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand completes in one edge.
//
// state | meaning
// IDLE  | waiting for opn_valid; operands latched on the accept edge
// BUSY  | one shift-add step per edge, WIDTH steps
// DONE  | res_valid high, result held until res_ready
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign,
  input  logic                 opn_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     prod;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;

  logic [WIDTH-1:0]     mcand_mag;
  logic [WIDTH-1:0]     mplr_mag;
  logic                 neg_in;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     prod_step;
  logic                 last;
  logic                 zero_op;

  // Operand magnitudes and one shift-add step of the product register.
  // The most negative operand negates to itself and is then read as unsigned.
  always_comb begin
    mcand_mag = (sign & a[WIDTH-1]) ? -a : a;
    mplr_mag  = (sign & b[WIDTH-1]) ? -b : b;
    neg_in    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    if (prod[0])
      prod_step = {1'b0, sum, prod[WIDTH-1:1]};
    else
      prod_step = {1'b0, prod[2*WIDTH:1]};
    last      = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_ZERO_SKIP_EN
    zero_op   = (a == '0) || (b == '0);
`else
    zero_op   = 1'b0;
`endif
  end

  // State register; res_valid is its own flop so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_valid <= (state_nxt == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (opn_valid) state_nxt = zero_op ? DONE : BUSY;
      BUSY: if (last)      state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Datapath: latch magnitudes on accept, iterate in BUSY, register the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (opn_valid) begin
            mcand <= mcand_mag;
            prod  <= {{(WIDTH+1){1'b0}}, mplr_mag};
            cnt   <= '0;
            neg   <= neg_in;
            if (zero_op) result <= '0;
          end
        end
        BUSY: begin
          prod <= prod_step;
          cnt  <= cnt + CNT_W'(1);
          if (last)
            result <= neg ? -prod_step[2*WIDTH-1:0] : prod_step[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
